// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared state, opcode and mux encodings for the LC-3 control sequencer
package lc3_pkg;

    typedef enum logic [3:0] {
        S_HALTED = 4'd0,
        S_FETCH,
        S_FRD,
        S_LDIR,
        S_DECODE,
        S_EXALU,
        S_BRCHK,
        S_BRTAKE,
        S_EXJMP,
        S_EXLEA,
        S_ADDR,
        S_DRD,
        S_WBR,
        S_SMDR,
        S_DWR,
        S_PAUSE
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // LDR/STR address from SR1+off6; LD/ST from PC+off9
    function automatic logic is_base_offset(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/ben_unit.sv
// rtl/ben_unit.sv - branch-enable register latched from IR[11:9] against n/z/p
module ben_unit (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ld,
    input  logic [2:0] i_cc_sel,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_p,
    output logic       o_ben
);

    logic r_ben;
    logic w_ben_next;

    assign w_ben_next = (i_cc_sel[2] & i_n) | (i_cc_sel[1] & i_z) | (i_cc_sel[0] & i_p);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ben <= 1'b0;
        else if (i_ld)
            r_ben <= w_ben_next;
    end

    assign o_ben = r_ben;

endmodule

// File: rtl/lc3_ctrl.sv
// rtl/lc3_ctrl.sv - multicycle LC-3 control sequencer: fetch, decode, execute
module lc3_ctrl
    import lc3_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_rdy,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_PC,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic [1:0]  ALUK,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_t     r_state;
    state_t     w_next;
    logic       w_ben;
    logic [3:0] w_op;
    logic       w_unused_ir;

    assign w_op        = IR[15:12];
    assign w_unused_ir = ^{IR[8:6], IR[4:0]};

    ben_unit u_ben (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_ld     (r_state == S_DECODE),
        .i_cc_sel (IR[11:9]),
        .i_n      (n),
        .i_z      (z),
        .i_p      (p),
        .o_ben    (w_ben)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= S_HALTED;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HALTED: if (Run) w_next = S_FETCH;
            S_FETCH:  w_next = S_FRD;
            S_FRD:    if (mem_rdy) w_next = S_LDIR;
            S_LDIR:   w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT:        w_next = S_EXALU;
                    OP_BR:                         w_next = S_BRCHK;
                    OP_JMP:                        w_next = S_EXJMP;
                    OP_LEA:                        w_next = S_EXLEA;
                    OP_LD, OP_LDR, OP_ST, OP_STR:  w_next = S_ADDR;
                    OP_PAUSE:                      w_next = S_PAUSE;
                    default:                       w_next = S_FETCH;
                endcase
            end
            S_BRCHK:  w_next = w_ben ? S_BRTAKE : S_FETCH;
            S_ADDR:   w_next = (w_op == OP_ST || w_op == OP_STR) ? S_SMDR : S_DRD;
            S_DRD:    if (mem_rdy) w_next = S_WBR;
            S_SMDR:   w_next = S_DWR;
            S_DWR:    if (mem_rdy) w_next = S_FETCH;
            S_PAUSE:  if (Continue) w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        LD_MAR = 1'b0;  LD_MDR = 1'b0;  LD_IR = 1'b0;
        LD_PC = 1'b0;   LD_REG = 1'b0;  LD_CC = 1'b0;
        GatePC = 1'b0;  GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = PCMUX_PC1;
        ADDR1MUX = 1'b0;
        ADDR2MUX = ADDR2_ZERO;
        DRMUX = 1'b0;   SR1MUX = 1'b0;  SR2MUX = 1'b0;
        ALUK = ALUK_ADD;
        Mem_OE = 1'b0;  Mem_WE = 1'b0;
        case (r_state)
            S_FETCH: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
            end
            S_FRD, S_DRD: begin
                Mem_OE = 1'b1; LD_MDR = mem_rdy;
            end
            S_LDIR: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
            end
            S_EXALU: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                SR2MUX  = (w_op != OP_NOT) & IR[5];
                ALUK    = (w_op == OP_AND) ? ALUK_AND :
                          (w_op == OP_NOT) ? ALUK_NOT : ALUK_ADD;
            end
            S_BRTAKE: begin
                LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR2MUX = ADDR2_OFF9;
            end
            S_EXJMP: begin
                LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR1MUX = 1'b1;
            end
            S_EXLEA: begin
                GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ADDR2MUX = ADDR2_OFF9;
            end
            S_ADDR: begin
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                ADDR1MUX   = is_base_offset(w_op);
                ADDR2MUX   = is_base_offset(w_op) ? ADDR2_OFF6 : ADDR2_OFF9;
            end
            S_WBR: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S_SMDR: begin
                GateALU = 1'b1; ALUK = ALUK_PASS; LD_MDR = 1'b1;
            end
            S_DWR:   Mem_WE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl.sv
// tb/tb_lc3_ctrl.sv - scoreboard bench for lc3_ctrl using directed instruction vectors
module tb_lc3_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Run, Continue, n, z, p, mem_rdy;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, DRMUX, SR1MUX, SR2MUX, Mem_OE, Mem_WE;

    lc3_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR),
        .n(n), .z(z), .p(p), .mem_rdy(mem_rdy),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
        .LD_REG(LD_REG), .LD_CC(LD_CC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
        .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    logic [21:0] w_out;
    assign w_out = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC,
                    GatePC, GateMDR, GateALU, GateMARMUX,
                    PCMUX, ADDR1MUX, ADDR2MUX, DRMUX, SR1MUX, SR2MUX, ALUK,
                    Mem_OE, Mem_WE};

    localparam logic [21:0] B_LD_MAR  = 22'd1 << 21;
    localparam logic [21:0] B_LD_MDR  = 22'd1 << 20;
    localparam logic [21:0] B_LD_IR   = 22'd1 << 19;
    localparam logic [21:0] B_LD_PC   = 22'd1 << 18;
    localparam logic [21:0] B_LD_REG  = 22'd1 << 17;
    localparam logic [21:0] B_LD_CC   = 22'd1 << 16;
    localparam logic [21:0] B_G_PC    = 22'd1 << 15;
    localparam logic [21:0] B_G_MDR   = 22'd1 << 14;
    localparam logic [21:0] B_G_ALU   = 22'd1 << 13;
    localparam logic [21:0] B_G_MARMX = 22'd1 << 12;
    localparam logic [21:0] B_PC_ADDR = 22'd2 << 10;
    localparam logic [21:0] B_A1_SR1  = 22'd1 << 9;
    localparam logic [21:0] B_A2_OFF6 = 22'd1 << 7;
    localparam logic [21:0] B_A2_OFF9 = 22'd2 << 7;
    localparam logic [21:0] B_SR2MUX  = 22'd1 << 4;
    localparam logic [21:0] B_AK_AND  = 22'd1 << 2;
    localparam logic [21:0] B_AK_NOT  = 22'd2 << 2;
    localparam logic [21:0] B_AK_PASS = 22'd3 << 2;
    localparam logic [21:0] B_MEM_OE  = 22'd1 << 1;
    localparam logic [21:0] B_MEM_WE  = 22'd1;

    localparam logic [21:0] E_ZERO  = 22'd0;
    localparam logic [21:0] E_FETCH = B_G_PC | B_LD_MAR | B_LD_PC;
    localparam logic [21:0] E_LDIR  = B_G_MDR | B_LD_IR;
    localparam logic [21:0] E_WRREG = B_LD_REG | B_LD_CC;

    typedef struct {
        logic [21:0] v;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge Clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (w_out !== e.v) begin
                errors++;
                $display("FAIL %s got %h want %h", e.nm, w_out, e.v);
            end
        end
        checks++;
        if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1 || (Mem_OE && Mem_WE)) begin
            errors++;
            $display("FAIL bus_strobe_exclusive got %h want at most one gate and not OE&WE", w_out);
        end
    end

    task automatic step(input logic [21:0] v, input string nm);
        sb_q.push_back('{v, nm});
        @(posedge Clk);
        #1;
    endtask

    // Starts in FETCH; ends with DECODE checked and the execute state next.
    task automatic fetch(input logic [15:0] ir, input int waits, input string nm);
        IR = ir;
        step(E_FETCH, {nm, "_fetch"});
        mem_rdy = 1'b0;
        for (int i = 0; i < waits; i++) step(B_MEM_OE, {nm, "_frd_wait"});
        mem_rdy = 1'b1;
        step(B_MEM_OE | B_LD_MDR, {nm, "_frd"});
        step(E_LDIR, {nm, "_ldir"});
        step(E_ZERO, {nm, "_decode"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6,
                             4'h7, 4'h9, 4'hC, 4'hD, 4'hE, 4'h8};

    initial begin
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; IR = 16'h0000;
        n = 1'b0; z = 1'b0; p = 1'b0; mem_rdy = 1'b0;
        @(posedge Clk); #1;
        step(E_ZERO, "reset_outputs");
        Reset = 1'b0;
        step(E_ZERO, "halted_no_run");
        Run = 1'b1; mem_rdy = 1'b1;
        step(E_ZERO, "halted_run");

        fetch(16'h1261, 0, "add");
        step(B_G_ALU | E_WRREG | B_SR2MUX, "add_exalu");

        z = 1'b1;
        fetch(16'h0402, 0, "brz_taken");
        z = 1'b0;
        step(E_ZERO, "brz_taken_brchk");
        step(B_LD_PC | B_PC_ADDR | B_A2_OFF9, "brz_taken_brtake");

        n = 1'b1;
        fetch(16'h0402, 1, "brz_nt");
        step(E_ZERO, "brz_nt_brchk");
        n = 1'b0;

        fetch(16'h927F, 0, "not");
        step(B_G_ALU | E_WRREG | B_AK_NOT, "not_exalu");

        fetch(16'h5042, 0, "and");
        step(B_G_ALU | E_WRREG | B_AK_AND, "and_exalu");

        fetch(16'h3005, 0, "st");
        mem_rdy = 1'b0;
        step(B_G_MARMX | B_LD_MAR | B_A2_OFF9, "st_addr");
        mem_rdy = 1'b1;
        step(B_G_ALU | B_AK_PASS | B_LD_MDR, "st_smdr");
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) step(B_MEM_WE, "st_dwr_wait");
        mem_rdy = 1'b1;
        step(B_MEM_WE, "st_dwr_done");

        fetch(16'h6242, 0, "ldr");
        step(B_G_MARMX | B_LD_MAR | B_A1_SR1 | B_A2_OFF6, "ldr_addr");
        mem_rdy = 1'b0;
        for (int i = 0; i < 2; i++) step(B_MEM_OE, "ldr_drd_wait");
        mem_rdy = 1'b1;
        step(B_MEM_OE | B_LD_MDR, "ldr_drd");
        step(B_G_MDR | E_WRREG, "ldr_wbr");

        fetch(16'hC080, 0, "jmp");
        step(B_LD_PC | B_PC_ADDR | B_A1_SR1, "jmp_exec");

        fetch(16'hE1FF, 0, "lea");
        step(B_G_MARMX | E_WRREG | B_A2_OFF9, "lea_exec");

        fetch(16'h8000, 0, "nop");

        fetch(16'hD000, 0, "pause");
        for (int i = 0; i < 3; i++) step(E_ZERO, "pause_hold");
        Continue = 1'b1;
        step(E_ZERO, "pause_release");
        Continue = 1'b0;

        IR = 16'h1261;
        step(E_FETCH, "rst_fetch");
        mem_rdy = 1'b0;
        step(B_MEM_OE, "rst_frd");
        Reset = 1'b1;
        step(E_ZERO, "rst_mid_frd");
        Reset = 1'b0; Run = 1'b0; mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) step(E_ZERO, "rst_halted_hold");
        Run = 1'b1;
        step(E_ZERO, "rst_halted_run");
        fetch(16'h1261, 0, "rerun");
        step(B_G_ALU | E_WRREG | B_SR2MUX, "rerun_exalu");

        for (int i = 0; i < 300; i++) begin
            IR = {ops[$urandom_range(0, 11)], 12'($urandom)};
            n = 1'($urandom); z = 1'($urandom); p = 1'($urandom);
            mem_rdy = 1'($urandom); Continue = 1'($urandom);
            @(posedge Clk); #1;
        end

        Reset = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
